spram_fifo_reader: RTL and testbench

Read-side stream adapter for the banked single-port-RAM FIFO. It drives the FIFO's `ren`, captures `rdata` one cycle later into a 2-entry prefetch buffer, and presents the data as a valid/ready stream. It sustains one beat per cycle under continuous `m_ready` and never presents a combinational path from `fifo_rdata` to `m_data`. It sits between the FIFO's read port and any downstream consumer.

---
 rtl/spram_fifo_reader.sv | 87 ++++++++
 tb/tb_spram_fifo_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spram_fifo_reader.sv
// Read-side stream adapter for the banked SPRAM FIFO: issues reads, lands data in a 2-entry
// prefetch buffer and presents it as valid/ready. Optional `SPRAM_FIFO_READER_BEAT_CNT_EN.
module spram_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef SPRAM_FIFO_READER_BEAT_CNT_EN
  ,
  output logic [15:0]           beat_cnt
`endif
);

  logic [1:0]            cnt_q, cnt_d;
  logic                  head_q, tail_q, inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  pop;
  logic [2:0]            credit;

  assign pop = m_valid & m_ready;

  // Occupancy once the in-flight word lands and this cycle's pop leaves; 3 bits, never wraps.
  assign credit = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign cnt_d  = credit[1:0];

  assign fifo_ren = !rst && !flush && !fifo_empty && (credit < 3'd2);
  assign m_valid  = (cnt_q != 2'd0);
  assign m_data   = buf_q[head_q];
  assign busy     = (cnt_q != 2'd0) || inflight_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q      <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= fifo_ren;
      if (inflight_q) begin
        tail_q <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  // Buffer contents survive flush; only reset clears them so m_data reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (inflight_q && !flush) begin
      buf_q[tail_q] <= fifo_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (credit <= 3'd2) else $error("spram_fifo_reader: occupancy out of range");
    end
  end

`ifdef SPRAM_FIFO_READER_BEAT_CNT_EN
  logic [15:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= 16'd0;
    end else if (pop) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_spram_fifo_reader.sv
// Self-checking bench for spram_fifo_reader: behavioural FIFO plus an in-order scoreboard.
module tb_spram_fifo_reader;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, flush, m_ready;
  logic         fifo_ren, m_valid, busy;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_rdata = '0;
  logic [W-1:0] m_data;
`ifdef SPRAM_FIFO_READER_BEAT_CNT_EN
  logic [15:0]  beat_cnt;
`endif

  int total = 0;
  int bad = 0;
  int ren_cnt = 0;
  int pop_cnt = 0;
  logic [W-1:0] fq [$];
  logic [W-1:0] sb [$];

  always #5 clk = ~clk;

  spram_fifo_reader #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef SPRAM_FIFO_READER_BEAT_CNT_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  // FIFO model: data one cycle after ren, registered empty flag, garbage when not read.
  always @(posedge clk) begin
    if (fifo_ren && fq.size() != 0) fifo_rdata <= fq.pop_front();
    else fifo_rdata <= W'($urandom);
    fifo_empty <= (fq.size() == 0);
  end

  always @(posedge clk) begin
    if (fifo_ren) ren_cnt++;
    if (m_valid && m_ready) pop_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, output int bubbles);
    bit started = 0;
    bubbles = 0;
    for (int i = 0; i < 400; i++) begin
      to_neg();
      if (m_valid && m_ready) begin
        chk(tag, m_data, sb.pop_front());
        started = 1;
      end else if (started) begin
        bubbles++;
      end
      to_pos();
      if (sb.size() == 0) break;
    end
    chk({tag, "_left"}, sb.size(), 0);
  endtask

  initial begin
    int bub, r0, p0, stable_err, outst, max_outst;
    logic [W-1:0] w0;

    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("rst_ren", fifo_ren, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_busy", busy, 0);
`ifdef SPRAM_FIFO_READER_BEAT_CNT_EN
      chk("rst_beat_cnt", beat_cnt, 0);
`endif
      to_pos();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("idle_ren", fifo_ren, 0);
      to_pos();
    end

    // Single word: ren in N only, valid in N+2, gone in N+3.
    m_ready = 1'b1;
    fq.push_back(8'hA5);
    for (int i = 0; i < 6; i++) begin
      to_neg();
      if (fifo_ren) break;
      to_pos();
    end
    chk("sw_ren_n", fifo_ren, 1);
    chk("sw_valid_n", m_valid, 0);
    to_pos(); to_neg();
    chk("sw_ren_n1", fifo_ren, 0);
    chk("sw_valid_n1", m_valid, 0);
    to_pos(); to_neg();
    chk("sw_valid_n2", m_valid, 1);
    chk("sw_data_n2", m_data, 8'hA5);
    to_pos(); to_neg();
    chk("sw_valid_n3", m_valid, 0);
    chk("sw_busy_n3", busy, 0);
    to_pos();

    // Streaming 32 words with m_ready held high.
    for (int i = 0; i < 32; i++) begin
      fq.push_back(W'(i));
      sb.push_back(W'(i));
    end
    drain("stream", bub);
    chk("stream_bubbles", bub, 0);
`ifdef SPRAM_FIFO_READER_BEAT_CNT_EN
    chk("stream_beat_cnt", beat_cnt, 16'(pop_cnt));
`endif

    // Backpressure: 8 queued, ready low for 10 cycles.
    m_ready = 1'b0;
    r0 = ren_cnt;
    for (int i = 0; i < 8; i++) begin
      fq.push_back(W'(8'h40 + i));
      sb.push_back(W'(8'h40 + i));
    end
    w0 = sb[0];
    stable_err = 0;
    for (int i = 0; i < 10; i++) begin
      to_neg();
      if (m_valid && m_data !== w0) stable_err++;
      to_pos();
    end
    chk("bp_ren_pulses", ren_cnt - r0, 2);
    chk("bp_stable", stable_err, 0);
    to_neg();
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, w0);
    to_pos();
    m_ready = 1'b1;
    drain("bp_drain", bub);

    // Flush with cnt == 1 and a read in flight.
    m_ready = 1'b0;
    fq.push_back(8'h77);
    for (int i = 0; i < 8; i++) begin
      to_neg();
      if (m_valid) break;
      to_pos();
    end
    chk("fl_prefill", m_valid, 1);
    to_pos();
    fq.push_back(8'h88);
    fq.push_back(8'h99);
    for (int i = 0; i < 8; i++) begin
      to_neg();
      if (fifo_ren) break;
      to_pos();
    end
    chk("fl_ren", fifo_ren, 1);
    to_pos();
    flush = 1'b1;
    to_neg();
    chk("fl_no_ren", fifo_ren, 0);
    to_pos();
    flush = 1'b0;
    to_neg();
    chk("fl_valid", m_valid, 0);
    chk("fl_busy", busy, 0);
    to_pos();
    sb.push_back(8'h99);
    m_ready = 1'b1;
    drain("fl_next", bub);
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) to_pos();
    chk("fl_no_extra", pop_cnt - p0, 0);

    // Random traffic against the in-order scoreboard.
    outst = 0;
    max_outst = 0;
    for (int c = 0; c < 1000; c++) begin
      m_ready = $urandom_range(1);
      if ($urandom_range(2) == 0) begin
        w0 = W'($urandom);
        fq.push_back(w0);
        sb.push_back(w0);
      end
      to_neg();
      chk("rnd_busy", busy, (outst != 0));
      if (m_valid && m_ready) begin
        if (sb.size() != 0) chk("rnd_data", m_data, sb.pop_front());
        else chk("rnd_extra_beat", sb.size(), 1);
        outst--;
      end
      if (fifo_ren) outst++;
      if (outst > max_outst) max_outst = outst;
      to_pos();
    end
    m_ready = 1'b1;
    drain("rnd_drain", bub);
    chk("rnd_outstanding_max", (max_outst <= 2), 1);
`ifdef SPRAM_FIFO_READER_BEAT_CNT_EN
    chk("rnd_beat_cnt", beat_cnt, 16'(pop_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
